// File: rtl/md_ctrl_if.sv
// md_ctrl issue/result bundle between the EX stage and the HI/LO unit.
// The master issues operations; the slave owns Busy and the HI/LO state.
interface md_ctrl_if;
   logic        Start;
   logic [2:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        Flush;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output Start, Op, A, B, Flush,
      input  Busy, HI, LO
   );

   modport slave (
      input  Start, Op, A, B, Flush,
      output Busy, HI, LO
   );
endinterface

// File: rtl/md_ctrl.sv
// Multi-cycle mult/div controller owning the architectural HI/LO pair.
// Fixed-latency RUN window; result committed on the last Busy cycle.
module md_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic      Clk,
   input logic      Reset,
   md_ctrl_if.slave bus
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                         MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t          r_state;
   state_t          w_state_n;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_n;
   // r_op[1]: divide, r_op[0]: unsigned
   logic [1:0]      r_op;
   logic [1:0]      w_op_n;
   logic [31:0]     r_a;
   logic [31:0]     w_a_n;
   logic [31:0]     r_b;
   logic [31:0]     w_b_n;
   logic [31:0]     r_hi;
   logic [31:0]     w_hi_n;
   logic [31:0]     r_lo;
   logic [31:0]     w_lo_n;

   logic            w_sgn;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [63:0]     w_a_ext;
   logic [63:0]     w_b_ext;
   logic [63:0]     w_prod;
   logic [31:0]     w_a_mag;
   logic [31:0]     w_b_mag;
   logic [31:0]     w_dvs;
   logic [31:0]     w_uq;
   logic [31:0]     w_ur;
   logic [31:0]     w_quo;
   logic [31:0]     w_rem;
   logic            w_b_zero;

   // Arithmetic on latched operands; signed divide via magnitudes so
   // 0x80000000 / -1 wraps cleanly and the remainder follows the dividend.
   always_comb begin
      w_sgn    = ~r_op[0];
      w_a_neg  = w_sgn & r_a[31];
      w_b_neg  = w_sgn & r_b[31];
      w_a_ext  = {{32{w_a_neg}}, r_a};
      w_b_ext  = {{32{w_b_neg}}, r_b};
      w_prod   = w_a_ext * w_b_ext;
      w_a_mag  = w_a_neg ? (32'd0 - r_a) : r_a;
      w_b_mag  = w_b_neg ? (32'd0 - r_b) : r_b;
      w_b_zero = (r_b == 32'd0);
      w_dvs    = w_b_zero ? 32'd1 : w_b_mag;
      w_uq     = w_a_mag / w_dvs;
      w_ur     = w_a_mag % w_dvs;
      w_quo    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
      w_rem    = w_a_neg ? (32'd0 - w_ur) : w_ur;
   end

   // Next-state: issue from IDLE, count down in RUN, commit or cancel.
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_op_n    = r_op;
      w_a_n     = r_a;
      w_b_n     = r_b;
      w_hi_n    = r_hi;
      w_lo_n    = r_lo;
      case (r_state)
         S_IDLE: begin
            if (bus.Start && !bus.Flush) begin
               case (bus.Op)
                  3'd0, 3'd1: begin
                     w_state_n = S_RUN;
                     w_cnt_n   = CW'(MULT_CYCLES);
                     w_op_n    = bus.Op[1:0];
                     w_a_n     = bus.A;
                     w_b_n     = bus.B;
                  end
                  3'd2, 3'd3: begin
                     w_state_n = S_RUN;
                     w_cnt_n   = CW'(DIV_CYCLES);
                     w_op_n    = bus.Op[1:0];
                     w_a_n     = bus.A;
                     w_b_n     = bus.B;
                  end
                  3'd4:    w_hi_n = bus.A;
                  3'd5:    w_lo_n = bus.A;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            if (bus.Flush) begin
               w_state_n = S_IDLE;
               w_cnt_n   = '0;
            end else if (r_cnt == CW'(1)) begin
               w_state_n = S_IDLE;
               w_cnt_n   = '0;
               if (!r_op[1]) begin
                  w_hi_n = w_prod[63:32];
                  w_lo_n = w_prod[31:0];
               end else if (!w_b_zero) begin
                  w_hi_n = w_rem;
                  w_lo_n = w_quo;
               end
            end else begin
               w_cnt_n = r_cnt - CW'(1);
            end
         end
         default: begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
         end
      endcase
   end

   // State, counter, operand and HI/LO registers.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_op    <= w_op_n;
         r_a     <= w_a_n;
         r_b     <= w_b_n;
         r_hi    <= w_hi_n;
         r_lo    <= w_lo_n;
      end
   end

   assign bus.Busy = (r_state == S_RUN);
   assign bus.HI   = r_hi;
   assign bus.LO   = r_lo;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: timing of Busy and HI/LO results,
// flush/reset cancellation, mthi/mtlo and back-to-back issue.
module tb_md_ctrl;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   md_ctrl_if bus ();

   md_ctrl #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) u_dut (
      .Clk   (clk),
      .Reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge of the first Busy cycle.
   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      bus.Start = 1'b1;
      bus.Op    = op;
      bus.A     = a;
      bus.B     = b;
      @(negedge clk);
      bus.Start = 1'b0;
   endtask

   // Checks n Busy cycles then the result in the first idle cycle.
   task automatic run(input string tag, input int n,
                      input logic [31:0] hi, input logic [31:0] lo);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_busy"}, {31'd0, bus.Busy}, 32'd1);
         @(negedge clk);
      end
      chk({tag, "_done"}, {31'd0, bus.Busy}, 32'd0);
      chk({tag, "_hi"}, bus.HI, hi);
      chk({tag, "_lo"}, bus.LO, lo);
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      bus.Start = 1'b0;
      bus.Flush = 1'b0;
      bus.Op    = 3'd0;
      bus.A     = 32'd0;
      bus.B     = 32'd0;

      // 1: reset, then signed mult -2 * 3
      step(2);
      rst_n = 1'b1;
      step(1);
      chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
      chk("rst_hi", bus.HI, 32'd0);
      chk("rst_lo", bus.LO, 32'd0);
      issue(3'd0, 32'hFFFF_FFFE, 32'd3);
      run("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

      // 2: multu, div, divu
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run("multu", 5, 32'hFFFF_FFFE, 32'h0000_0001);
      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      run("div_neg", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      issue(3'd3, 32'd7, 32'd2);
      run("divu", 10, 32'd1, 32'd3);

      // 3: mthi/mtlo, divide by zero, overflow divide
      issue(3'd4, 32'h11, 32'd0);
      chk("mthi_busy", {31'd0, bus.Busy}, 32'd0);
      chk("mthi_hi", bus.HI, 32'h11);
      issue(3'd5, 32'h22, 32'd0);
      chk("mtlo_busy", {31'd0, bus.Busy}, 32'd0);
      chk("mtlo_lo", bus.LO, 32'h22);
      issue(3'd2, 32'd5, 32'd0);
      run("div0", 10, 32'h11, 32'h22);
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      run("div_ovf", 10, 32'd0, 32'h8000_0000);

      // 4: flush mid-run, flush on last cycle, flushed mthi
      issue(3'd0, 32'd3, 32'd4);
      step(2);
      chk("fl_mid_busy3", {31'd0, bus.Busy}, 32'd1);
      bus.Flush = 1'b1;
      @(negedge clk);
      bus.Flush = 1'b0;
      chk("fl_mid_busy", {31'd0, bus.Busy}, 32'd0);
      chk("fl_mid_hi", bus.HI, 32'd0);
      chk("fl_mid_lo", bus.LO, 32'h8000_0000);
      step(6);
      chk("fl_mid_stay", {31'd0, bus.Busy}, 32'd0);
      chk("fl_mid_lo2", bus.LO, 32'h8000_0000);
      issue(3'd0, 32'd3, 32'd4);
      step(4);
      chk("fl_end_busy5", {31'd0, bus.Busy}, 32'd1);
      bus.Flush = 1'b1;
      @(negedge clk);
      bus.Flush = 1'b0;
      chk("fl_end_busy", {31'd0, bus.Busy}, 32'd0);
      chk("fl_end_hi", bus.HI, 32'd0);
      chk("fl_end_lo", bus.LO, 32'h8000_0000);
      bus.Flush = 1'b1;
      issue(3'd4, 32'hDEAD_BEEF, 32'd0);
      bus.Flush = 1'b0;
      chk("fl_mthi_busy", {31'd0, bus.Busy}, 32'd0);
      chk("fl_mthi_hi", bus.HI, 32'd0);

      // reserved op is a no-op
      issue(3'd6, 32'h1234, 32'h5678);
      chk("rsv_busy", {31'd0, bus.Busy}, 32'd0);
      chk("rsv_hi", bus.HI, 32'd0);
      chk("rsv_lo", bus.LO, 32'h8000_0000);

      // 5: Start during RUN ignored; reset mid-run
      issue(3'd2, 32'd100, 32'd7);
      chk("ign_busy1", {31'd0, bus.Busy}, 32'd1);
      issue(3'd0, 32'd9, 32'd9);
      run("ign_div", 9, 32'd2, 32'd14);
      issue(3'd3, 32'd50, 32'd3);
      step(3);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mrst_busy", {31'd0, bus.Busy}, 32'd0);
      chk("mrst_hi", bus.HI, 32'd0);
      chk("mrst_lo", bus.LO, 32'd0);

      // 6: back-to-back div then mult
      issue(3'd2, 32'd20, 32'd6);
      run("b2b_div", 10, 32'd2, 32'd3);
      issue(3'd0, 32'd6, 32'd7);
      for (int i = 0; i < 5; i++) begin
         chk("b2b_busy", {31'd0, bus.Busy}, 32'd1);
         chk("b2b_win_hi", bus.HI, 32'd2);
         chk("b2b_win_lo", bus.LO, 32'd3);
         @(negedge clk);
      end
      chk("b2b_done", {31'd0, bus.Busy}, 32'd0);
      chk("b2b_hi", bus.HI, 32'd0);
      chk("b2b_lo", bus.LO, 32'd42);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
